// File: rtl/nfca_tx_frame_player_if.sv
// nfca_tx_frame_player_if
//   Byte stream from the frame player into nfca_controller's tx port.
//   Signals:
//     tx_tvalid  beat valid (player -> controller)
//     tx_tready  controller ready (controller -> player)
//     tx_tdata   beat byte
//     tx_tdatab  valid bits of tx_tdata (8 except possibly the last beat)
//     tx_tlast   last beat of the frame
//   Modports: master = frame player side, slave = controller side.
interface nfca_tx_frame_player_if;
   logic       tx_tvalid;
   logic       tx_tready;
   logic [7:0] tx_tdata;
   logic [3:0] tx_tdatab;
   logic       tx_tlast;

   modport master (
      output tx_tvalid,
      output tx_tdata,
      output tx_tdatab,
      output tx_tlast,
      input  tx_tready
   );

   modport slave (
      input  tx_tvalid,
      input  tx_tdata,
      input  tx_tdatab,
      input  tx_tlast,
      output tx_tready
   );
endinterface

// File: rtl/nfca_tx_frame_player.sv
// nfca_tx_frame_player
//   PCD-side frame source for the nfca_controller tx stream. A host-loaded byte
//   buffer is replayed as one frame, cfg_repeat times (0 = until stop), with a
//   programmable idle gap between frames and a partial last byte.
//   Optional build macro NFCA_TX_CRC_EN: adds cfg_crc; when set (and the last
//   byte is a full byte) CRC_A is appended as two extra beats, low byte first.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ld_en/ld_addr/ld_data     buffer write port (accepted only while idle)
//   cfg_len/datab/repeat/gap  frame config, snapshotted on start
//   cfg_crc                   append CRC_A (NFCA_TX_CRC_EN builds only)
//   start, stop               1-cycle control pulses
//   busy, done, frame_cnt     status
//   tx                        stream master (tvalid/tready/tdata/tdatab/tlast)
module nfca_tx_frame_player #(
   parameter int AW    = 5,
   parameter int GAP_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld_en,
   input  logic [AW-1:0]        ld_addr,
   input  logic [7:0]           ld_data,
   input  logic [AW:0]          cfg_len,
   input  logic [3:0]           cfg_datab,
   input  logic [7:0]           cfg_repeat,
   input  logic [GAP_W-1:0]     cfg_gap,
`ifdef NFCA_TX_CRC_EN
   input  logic                 cfg_crc,
`endif
   input  logic                 start,
   input  logic                 stop,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           frame_cnt,
   nfca_tx_frame_player_if.master tx
);

   localparam int DEPTH = 2 ** AW;
   // beat index must reach len+1 (two CRC beats past the payload)
   localparam int IW    = AW + 2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [7:0]       mem_q [DEPTH];

   logic [1:0]       state_q,     state_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic             tvalid_q,    tvalid_d;
   logic [7:0]       tdata_q,     tdata_d;
   logic [3:0]       tdatab_q,    tdatab_d;
   logic             tlast_q,     tlast_d;
   logic [IW-1:0]    idx_q,       idx_d;
   logic [IW-1:0]    len_q,       len_d;
   logic [IW-1:0]    tot_q,       tot_d;
   logic [3:0]       datab_q,     datab_d;
   logic [7:0]       repeat_q,    repeat_d;
   logic [GAP_W-1:0] gap_q,       gap_d;
   logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
   logic             stop_q,      stop_d;
`ifdef NFCA_TX_CRC_EN
   logic [15:0]      crc_q,       crc_d;
   logic [15:0]      crc_upd;
`endif

   logic [3:0]       cfg_datab_eff;
   logic             cfg_crc_on;
   logic [IW-1:0]    cfg_len_ext;
   logic [IW-1:0]    cfg_tot;
   logic [IW-1:0]    b_len, b_tot, nidx;
   logic [3:0]       b_datab;
   logic [7:0]       nb_data;
   logic [3:0]       nb_datab;
   logic             nb_last;
   logic [7:0]       frame_cnt_inc;
   logic             frame_end;

`ifdef NFCA_TX_CRC_EN
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int unsigned i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      return r;
   endfunction
`endif

   // Effective config as it would be snapshotted by a start this cycle.
   always_comb begin
      cfg_datab_eff = (cfg_datab == 4'd0 || cfg_datab > 4'd8) ? 4'd8 : cfg_datab;
`ifdef NFCA_TX_CRC_EN
      cfg_crc_on    = cfg_crc && (cfg_datab_eff == 4'd8);
`else
      cfg_crc_on    = 1'b0;
`endif
      cfg_len_ext   = IW'(cfg_len);
      cfg_tot       = cfg_len_ext + (cfg_crc_on ? IW'(2) : IW'(0));
   end

   // Contents of the beat that would be presented next: beat 0 when leaving
   // IDLE/GAP, beat idx+1 after a handshake in SEND. Registering this keeps
   // the stream outputs flop-driven.
   always_comb begin
      b_len    = (state_q == S_IDLE) ? cfg_len_ext   : len_q;
      b_tot    = (state_q == S_IDLE) ? cfg_tot       : tot_q;
      b_datab  = (state_q == S_IDLE) ? cfg_datab_eff : datab_q;
      nidx     = (state_q == S_SEND) ? idx_q + IW'(1) : '0;
`ifdef NFCA_TX_CRC_EN
      crc_upd  = crc_step(crc_q, tdata_q);
`endif
      if (nidx < b_len)
         nb_data = mem_q[nidx[AW-1:0]];
`ifdef NFCA_TX_CRC_EN
      // crc_upd folds in the payload byte being handshaked right now
      else if (nidx == b_len)
         nb_data = crc_upd[7:0];
      else
         nb_data = crc_q[15:8];
`else
      else
         nb_data = 8'h00;
`endif
      nb_last  = (nidx == b_tot - IW'(1));
      nb_datab = nb_last ? b_datab : 4'd8;
   end

   always_comb begin
      frame_cnt_inc = frame_cnt_q + 8'd1;
      frame_end     = stop_q || stop || (repeat_q != 8'd0 && frame_cnt_inc == repeat_q);
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      tvalid_d    = tvalid_q;
      tdata_d     = tdata_q;
      tdatab_d    = tdatab_q;
      tlast_d     = tlast_q;
      idx_d       = idx_q;
      len_d       = len_q;
      tot_d       = tot_q;
      datab_d     = datab_q;
      repeat_d    = repeat_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      stop_d      = stop_q;
`ifdef NFCA_TX_CRC_EN
      crc_d       = crc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_len != '0) begin
                  state_d     = S_SEND;
                  busy_d      = 1'b1;
                  frame_cnt_d = 8'd0;
                  idx_d       = '0;
                  stop_d      = stop;
                  len_d       = cfg_len_ext;
                  tot_d       = cfg_tot;
                  datab_d     = cfg_datab_eff;
                  repeat_d    = cfg_repeat;
                  gap_d       = cfg_gap;
                  tvalid_d    = 1'b1;
                  tdata_d     = nb_data;
                  tdatab_d    = nb_datab;
                  tlast_d     = nb_last;
`ifdef NFCA_TX_CRC_EN
                  crc_d       = 16'h6363;
`endif
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_SEND: begin
            stop_d = stop_q || stop;
            if (tx.tx_tready) begin
               if (tlast_q) begin
                  frame_cnt_d = frame_cnt_inc;
                  tvalid_d    = 1'b0;
                  tdata_d     = 8'h00;
                  tdatab_d    = 4'd0;
                  tlast_d     = 1'b0;
                  if (frame_end) begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = S_GAP;
                     gap_cnt_d = (gap_q == '0) ? GAP_W'(1) : gap_q;
                  end
               end else begin
                  idx_d    = nidx;
                  tdata_d  = nb_data;
                  tdatab_d = nb_datab;
                  tlast_d  = nb_last;
`ifdef NFCA_TX_CRC_EN
                  if (idx_q < len_q)
                     crc_d = crc_upd;
`endif
               end
            end
         end
         S_GAP: begin
            stop_d = stop_q || stop;
            if (stop_q || stop) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (gap_cnt_q <= GAP_W'(1)) begin
               state_d  = S_SEND;
               idx_d    = '0;
               tvalid_d = 1'b1;
               tdata_d  = nb_data;
               tdatab_d = nb_datab;
               tlast_d  = nb_last;
`ifdef NFCA_TX_CRC_EN
               crc_d    = 16'h6363;
`endif
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Buffer has no reset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (ld_en && state_q == S_IDLE)
         mem_q[ld_addr] <= ld_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= 8'd0;
         tvalid_q    <= 1'b0;
         tdata_q     <= 8'h00;
         tdatab_q    <= 4'd0;
         tlast_q     <= 1'b0;
         idx_q       <= '0;
         len_q       <= '0;
         tot_q       <= '0;
         datab_q     <= 4'd8;
         repeat_q    <= 8'd0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         stop_q      <= 1'b0;
`ifdef NFCA_TX_CRC_EN
         crc_q       <= 16'h6363;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
         tvalid_q    <= tvalid_d;
         tdata_q     <= tdata_d;
         tdatab_q    <= tdatab_d;
         tlast_q     <= tlast_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         tot_q       <= tot_d;
         datab_q     <= datab_d;
         repeat_q    <= repeat_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         stop_q      <= stop_d;
`ifdef NFCA_TX_CRC_EN
         crc_q       <= crc_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign frame_cnt    = frame_cnt_q;
   assign tx.tx_tvalid = tvalid_q;
   assign tx.tx_tdata  = tdata_q;
   assign tx.tx_tdatab = tdatab_q;
   assign tx.tx_tlast  = tlast_q;

endmodule
